clkdiv_ctrl: RTL and testbench
==============================

Name: clkdiv_ctrl

Overview:
Run-time controller for a toggle-style clock divider used by the instrument datapath. Host logic loads divide ratios through a valid/ready handshake. Host logic then starts continuous or fixed-length (burst) output. New ratios switch in glitch-free, only at full-period boundaries. The block drives the divided pulse, a per-edge tick strobe and status flags consumed by downstream sequencers.

Parameters:
CNT_W, 16, width of divide ratio and internal cycle counter
BURST_W, 16, width of burst period counter
DEFAULT_DIV, 1, ratio loaded into active_div at reset (must be >=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
cfg_div  in  CNT_W  requested half-period in clk cycles; 0 treated as 1
cfg_valid  in  1  cfg_div valid
cfg_ready  out  1  controller can accept a new ratio
start  in  1  single-cycle request to begin output
stop  in  1  single-cycle request to end output at next period boundary
burst_len  in  BURST_W  full periods to emit, sampled with start; 0 = continuous
pulse  out  1  divided output, 50% duty, period 2*active_div cycles
tick  out  1  one-cycle strobe coincident with every pulse toggle
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle strobe when a burst completes or a stop completes
active_div  out  CNT_W  ratio currently in use

Behaviour:
- Reset (reset=0, async): state IDLE, pulse=0, tick=0, busy=0, done=0, cfg_ready=1, active_div=DEFAULT_DIV, counters=0, pending flag cleared.
- States: IDLE, RUN, DRAIN.
- Config handshake: transfer on cfg_valid&&cfg_ready at a clk edge. cfg_div=0 is stored as 1.
  - In IDLE: active_div updates on the same edge; cfg_ready stays 1.
  - In RUN/DRAIN: value goes to a pending register, cfg_ready drops to 0 the next cycle, and a second transfer cannot occur until the pending value is applied.
  - Pending applies on the edge where pulse toggles 1->0. cnt restarts at 0 with the new ratio. cfg_ready returns to 1 on that same edge.
- IDLE->RUN: on start=1 && stop=0. cnt=0, pulse=0, burst_cnt=0, burst_len latched, busy=1 from the next cycle.
  - start and stop in the same IDLE cycle: stay IDLE, no done.
  - start while busy: ignored.
- RUN counting:
  - Each cycle, if cnt==active_div-1 then pulse toggles, tick=1 that cycle, and cnt=0; otherwise cnt increments.
  - First rising edge of pulse occurs active_div cycles after the start edge.
  - Each 1->0 toggle is one completed period; burst_cnt increments.
- Burst end: when latched burst_len!=0 and burst_cnt reaches burst_len on a 1->0 toggle, go to IDLE and assert done for one cycle. pulse is already 0.
- Stop in RUN:
  - If pulse=0 and cnt==0 (start-of-period edge), go to IDLE immediately with done.
  - Otherwise go to DRAIN. DRAIN keeps counting and toggling, and exits to IDLE with done on the next 1->0 toggle.
  - stop in DRAIN or IDLE: no effect.
- Burst completion and stop on the same edge: single done, IDLE.
- Pending config still held on entry to IDLE is applied to active_div on that edge.
- pulse is never left high in IDLE. A full-period boundary always precedes IDLE.
- Counter compare uses CNT_W-bit unsigned. active_div max 2^CNT_W-1; no wrap possible since cnt resets at compare.
- Reset mid-operation: outputs return to reset values immediately (asynchronous), including pulse=0 mid-high-phase. Latched burst and pending config are discarded.

Test Plan:
- Reset, load cfg_div=3 in IDLE, start with burst_len=0 -> active_div=3 same edge; pulse rises 3 cycles after start edge, period 6, tick every 3 cycles, busy=1.
- DEFAULT_DIV=1, start with burst_len=4 -> pulse toggles every cycle, 4 full periods (8 ticks), then done strobe once, busy=0, pulse=0.
- Running at div=4, send cfg_div=2 mid-high-phase -> cfg_ready low until the next 1->0 toggle; subsequent half-periods are 2 cycles; no runt pulse shorter than 2 cycles.
- Running at div=5, stop asserted 2 cycles into the high phase -> DRAIN; pulse completes high phase (3 more cycles), falls, done on that edge, IDLE.
- cfg_div=0 in IDLE then start -> active_div=1, pulse toggles every cycle; start+stop same cycle in IDLE -> stays IDLE, no done.
- Deassert reset to 0 while pulse=1 in RUN with burst_len=10 -> pulse, busy, tick drop without waiting for clk; after release, IDLE with active_div=DEFAULT_DIV and cfg_ready=1.

Source files
------------

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run-time toggle clock divider with glitch-free ratio switching, burst and stop control
module clkdiv_ctrl #(
  parameter int CNT_W       = 16,
  parameter int BURST_W     = 16,
  parameter int DEFAULT_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  output logic               pulse,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   active_div
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d, nv;
  logic [BURST_W-1:0] bcnt_q, bcnt_d, blen_q, blen_d;
  logic pend_v_q, pend_v_d, pulse_q, pulse_d, tick_q, tick_d, done_q, done_d, busy_q;
  logic accept, wrap, fall, quit;
  always_comb begin
    nv       = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    accept   = cfg_valid && !pend_v_q;
    wrap     = (state_q != IDLE) && (cnt_q == div_q - 1'b1);
    fall     = wrap && pulse_q;
    quit     = (fall && (state_q == DRAIN || stop || (blen_q != '0 && bcnt_q + 1'b1 == blen_q)))
            || (state_q == RUN && stop && !pulse_q && cnt_q == '0);
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    pulse_d  = pulse_q;
    bcnt_d   = bcnt_q;
    blen_d   = blen_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      div_d = accept ? nv : div_q;
      if (start && !stop) begin
        state_d = RUN;
        cnt_d   = '0;
        pulse_d = 1'b0;
        bcnt_d  = '0;
        blen_d  = burst_len;
      end
    end else if (quit) begin
      state_d  = IDLE;
      done_d   = 1'b1;
      tick_d   = fall;
      pulse_d  = 1'b0;
      cnt_d    = '0;
      pend_v_d = 1'b0;
      div_d    = accept ? nv : pend_v_q ? pend_q : div_q;
    end else begin
      state_d = (stop && state_q == RUN) ? DRAIN : state_q;
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      pulse_d = pulse_q ^ wrap;
      tick_d  = wrap;
      bcnt_d  = fall ? bcnt_q + 1'b1 : bcnt_q;
      div_d   = (fall && pend_v_q) ? pend_q : div_q;
      pend_v_d = accept ? 1'b1 : (fall ? 1'b0 : pend_v_q);
      pend_d  = accept ? nv : pend_q;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= CNT_W'(DEFAULT_DIV);
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      pulse_q  <= 1'b0;
      bcnt_q   <= '0;
      blen_q   <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      pulse_q  <= pulse_d;
      bcnt_q   <= bcnt_d;
      blen_q   <= blen_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      busy_q   <= (state_d != IDLE);
    end
  end
  assign cfg_ready  = !pend_v_q;
  assign pulse      = pulse_q;
  assign tick       = tick_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign active_div = div_q;
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed stimulus with tick/done scoreboard for clkdiv_ctrl
module tb_clkdiv_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic [15:0] cfg_div = '0, burst_len = '0;
  logic cfg_valid = 1'b0, start = 1'b0, stop = 1'b0;
  logic cfg_ready, pulse, tick, busy, done;
  logic [15:0] active_div;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int c; int p;} tick_t;
  tick_t tq[$];
  tick_t t;
  int dq[$];
  int dc;

  clkdiv_ctrl dut (
    .clk(clk), .reset(reset), .cfg_div(cfg_div), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .start(start), .stop(stop), .burst_len(burst_len), .pulse(pulse), .tick(tick),
    .busy(busy), .done(done), .active_div(active_div)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (tick) begin
      if (tq.size() == 0) begin
        checks++; errors++;
        $display("FAIL tick_unexpected got 1 want 0 (cycle %0d)", cyc);
      end else begin
        t = tq.pop_front();
        chk("tick_cycle", cyc, t.c);
        chk("tick_pulse", int'(pulse), t.p);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected got 1 want 0 (cycle %0d)", cyc);
      end else begin
        dc = dq.pop_front();
        chk("done_cycle", cyc, dc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask
  task automatic load(input int d);
    cfg_div = 16'(d); cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
  endtask
  task automatic go(input int bl, output int s);
    burst_len = 16'(bl); start = 1'b1; s = cyc + 1; step(); start = 1'b0;
  endtask
  task automatic exp_ticks(input int s, input int d, input int n);
    for (int k = 1; k <= n; k++) tq.push_back('{s + d * k, k % 2});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    #12;
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_active_div", int'(active_div), 1);
    @(negedge clk); reset = 1'b1; step();
    // continuous run at div 3, stopped at a period boundary
    load(3);
    chk("t1_div", int'(active_div), 3);
    chk("t1_ready", int'(cfg_ready), 1);
    go(0, s);
    chk("t1_busy", int'(busy), 1);
    exp_ticks(s, 3, 4);
    wait_cyc(s + 3);
    chk("t1_rise", int'(pulse), 1);
    wait_cyc(s + 12);
    dq.push_back(s + 13);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t1_idle", int'(busy), 0);
    // burst of 4 periods at div 1
    load(1);
    go(4, s);
    exp_ticks(s, 1, 8);
    dq.push_back(s + 8);
    wait_cyc(s + 8);
    chk("t2_busy", int'(busy), 0);
    chk("t2_pulse", int'(pulse), 0);
    step();
    chk("t2_done_once", int'(done), 0);
    // ratio change 4 -> 2 mid-high-phase; second request blocked while pending
    load(4);
    go(0, s);
    exp_ticks(s, 4, 2);
    tq.push_back('{s + 10, 1}); tq.push_back('{s + 12, 0});
    tq.push_back('{s + 14, 1}); tq.push_back('{s + 16, 0});
    wait_cyc(s + 5);
    cfg_div = 16'd2; cfg_valid = 1'b1; step();
    cfg_div = 16'd7;
    chk("t3_ready_low", int'(cfg_ready), 0);
    chk("t3_div_hold", int'(active_div), 4);
    step();
    chk("t3_ready_low2", int'(cfg_ready), 0);
    step();
    cfg_valid = 1'b0;
    chk("t3_div_new", int'(active_div), 2);
    chk("t3_ready_back", int'(cfg_ready), 1);
    wait_cyc(s + 16);
    dq.push_back(s + 17);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t3_idle", int'(busy), 0);
    chk("t3_div_final", int'(active_div), 2);
    // stop two cycles into the high phase at div 5 drains to the fall
    load(5);
    go(0, s);
    tq.push_back('{s + 5, 1}); tq.push_back('{s + 10, 0});
    dq.push_back(s + 10);
    wait_cyc(s + 6);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4_drain_busy", int'(busy), 1);
    chk("t4_drain_pulse", int'(pulse), 1);
    wait_cyc(s + 10);
    chk("t4_idle", int'(busy), 0);
    chk("t4_pulse", int'(pulse), 0);
    // cfg 0 maps to 1; start+stop together stays idle; start while busy ignored
    load(0);
    chk("t5_div_zero", int'(active_div), 1);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0; step();
    chk("t5_startstop_idle", int'(busy), 0);
    go(2, s);
    exp_ticks(s, 1, 4);
    dq.push_back(s + 4);
    burst_len = 16'd0; start = 1'b1; step(); start = 1'b0;
    wait_cyc(s + 4);
    chk("t5_burst_end", int'(busy), 0);
    // asynchronous reset while pulse high with a pending ratio
    load(3);
    go(10, s);
    wait_cyc(s + 1);
    cfg_div = 16'd9; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
    step();
    chk("t6_pre_pulse", int'(pulse), 1);
    chk("t6_pre_tick", int'(tick), 1);
    chk("t6_pre_ready", int'(cfg_ready), 0);
    reset = 1'b0;
    #1;
    chk("t6_async_pulse", int'(pulse), 0);
    chk("t6_async_tick", int'(tick), 0);
    chk("t6_async_busy", int'(busy), 0);
    chk("t6_async_ready", int'(cfg_ready), 1);
    chk("t6_async_div", int'(active_div), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step(); step();
    chk("t6_post_busy", int'(busy), 0);
    chk("t6_post_div", int'(active_div), 1);
    chk("t6_post_ready", int'(cfg_ready), 1);
    repeat (5) step();
    chk("ticks_missing", tq.size(), 0);
    chk("dones_missing", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
